alu_flag_unit: RTL and testbench

//   Execute stage of the multi-cycle accumulator CPU, directly downstream of the controller.
//   - Holds operand registers A and B, the ALU, the result register and the C/Z/N flag register.
//   - Is driven by the controller's aRegWriteEn/bRegWriteEn/RegAOr0/RegBOr0/aluOpControl/

---
 rtl/alu_flag_unit.sv | 121 ++++++++++++
 tb/tb_alu_flag_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Execute stage of the accumulator CPU: operand registers, ALU, result and C/Z/N flag registers.
// Define ALU_OVF_EN to add the registered signed-overflow flag output vFlag.
module alu_flag_unit #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] aIn,
    input  logic [W-1:0] bIn,
    input  logic         aRegWriteEn,
    input  logic         bRegWriteEn,
    input  logic         RegAOr0,
    input  logic         RegBOr0,
    input  logic [1:0]   aluOpControl,
    input  logic         aluResWriteEn,
    input  logic         ldCZN,
    output logic [W-1:0] aluRes,
    output logic [2:0]   CznToCU
`ifdef ALU_OVF_EN
    ,
    output logic         vFlag
`endif
);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpAnd = 2'b10;
    localparam logic [1:0] OpNot = 2'b11;

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] res_q, res_d;
    logic [2:0]   czn_q, czn_d;

    logic [W-1:0] op_a, op_b;
    logic [W:0]   sum;
    logic [W-1:0] alu_r;
    logic         alu_c;
    logic         alu_z;
    logic         alu_n;

    // ALU always sees the registered operands, so a same-cycle load is used one cycle later.
    always_comb begin
        op_a = RegAOr0 ? '0 : a_q;
        op_b = RegBOr0 ? '0 : b_q;
    end

    always_comb begin
        sum   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        unique case (aluOpControl)
            OpAdd: begin
                sum   = {1'b0, op_a} + {1'b0, op_b};
                alu_r = sum[W-1:0];
                alu_c = sum[W];
            end
            OpSub: begin
                // Carry out of a + ~b + 1 is the inverted borrow.
                sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, 1'b1};
                alu_r = sum[W-1:0];
                alu_c = sum[W];
            end
            OpAnd: alu_r = op_a & op_b;
            OpNot: alu_r = ~op_b;
            default: alu_r = '0;
        endcase
        alu_z = (alu_r == '0);
        alu_n = alu_r[W-1];
    end

    always_comb begin
        a_d   = aRegWriteEn   ? aIn   : a_q;
        b_d   = bRegWriteEn   ? bIn   : b_q;
        res_d = aluResWriteEn ? alu_r : res_q;
        czn_d = ldCZN ? {alu_c, alu_z, alu_n} : czn_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            czn_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            czn_q <= czn_d;
        end
    end

    assign aluRes  = res_q;
    assign CznToCU = czn_q;

`ifdef ALU_OVF_EN
    logic v_q, v_d;
    logic alu_v;

    always_comb begin
        alu_v = 1'b0;
        unique case (aluOpControl)
            OpAdd: alu_v = (op_a[W-1] == op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
            OpSub: alu_v = (op_a[W-1] != op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
            default: alu_v = 1'b0;
        endcase
        v_d = ldCZN ? alu_v : v_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign vFlag = v_q;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed, table-driven bench for alu_flag_unit (W=8), plus hand sequences for
// same-cycle load, asynchronous reset and the optional overflow flag.
module tb_alu_flag_unit;

    logic       clk;
    logic       rst;
    logic [7:0] aIn, bIn;
    logic       aRegWriteEn, bRegWriteEn, RegAOr0, RegBOr0;
    logic [1:0] aluOpControl;
    logic       aluResWriteEn, ldCZN;
    logic [7:0] aluRes;
    logic [2:0] CznToCU;
`ifdef ALU_OVF_EN
    logic       vFlag;
`endif

    int total;
    int bad;

    alu_flag_unit #(.W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .aIn          (aIn),
        .bIn          (bIn),
        .aRegWriteEn  (aRegWriteEn),
        .bRegWriteEn  (bRegWriteEn),
        .RegAOr0      (RegAOr0),
        .RegBOr0      (RegBOr0),
        .aluOpControl (aluOpControl),
        .aluResWriteEn(aluResWriteEn),
        .ldCZN        (ldCZN),
        .aluRes       (aluRes),
        .CznToCU      (CznToCU)
`ifdef ALU_OVF_EN
        ,
        .vFlag        (vFlag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       aen;
        logic       ben;
        logic       az;
        logic       bz;
        logic [1:0] op;
        logic       res;
        logic       ld;
        logic [7:0] exp_res;
        logic [2:0] exp_czn;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs[NVec];

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic aen,
                                input logic ben, input logic az, input logic bz,
                                input logic [1:0] op, input logic res, input logic ld,
                                input logic [7:0] er, input logic [2:0] ec);
        vec_t v;
        v.a = a; v.b = b; v.aen = aen; v.ben = ben; v.az = az; v.bz = bz;
        v.op = op; v.res = res; v.ld = ld; v.exp_res = er; v.exp_czn = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of strobes; outputs sampled 1ns after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic aen,
                        input logic ben, input logic az, input logic bz, input logic [1:0] op,
                        input logic res, input logic ld);
        aIn = a; bIn = b; aRegWriteEn = aen; bRegWriteEn = ben;
        RegAOr0 = az; RegBOr0 = bz; aluOpControl = op; aluResWriteEn = res; ldCZN = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        aIn = '0; bIn = '0; aRegWriteEn = 0; bRegWriteEn = 0;
        RegAOr0 = 0; RegBOr0 = 0; aluOpControl = 2'b00; aluResWriteEn = 0; ldCZN = 0;

        //            a      b      aen ben az bz op     res ld  exp_res exp_czn
        vecs[0]  = mk(8'hF0, 8'h20, 1, 1, 0, 0, 2'b00, 0, 0, 8'h00, 3'b000);
        vecs[1]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1, 8'h10, 3'b100);
        vecs[2]  = mk(8'h33, 8'h33, 1, 1, 0, 0, 2'b00, 0, 0, 8'h10, 3'b100);
        vecs[3]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b01, 1, 1, 8'h00, 3'b110);
        vecs[4]  = mk(8'h01, 8'h02, 1, 1, 0, 0, 2'b00, 0, 0, 8'h00, 3'b110);
        vecs[5]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b01, 1, 1, 8'hFF, 3'b001);
        vecs[6]  = mk(8'h00, 8'h00, 1, 1, 0, 0, 2'b00, 0, 0, 8'hFF, 3'b001);
        vecs[7]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1, 8'h00, 3'b010);
        vecs[8]  = mk(8'h77, 8'h55, 1, 1, 0, 0, 2'b00, 0, 0, 8'h00, 3'b010);
        vecs[9]  = mk(8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0, 8'h77, 3'b010);
        vecs[10] = mk(8'h00, 8'h80, 0, 1, 0, 0, 2'b00, 0, 0, 8'h77, 3'b010);
        vecs[11] = mk(8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 1, 0, 8'h80, 3'b010);
        vecs[12] = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 1, 1, 8'h00, 3'b010);
        vecs[13] = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b11, 1, 1, 8'h7F, 3'b000);
        vecs[14] = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b01, 1, 1, 8'hF7, 3'b001);
        vecs[15] = mk(8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 0, 1, 8'hF7, 3'b010);
        vecs[16] = mk(8'h00, 8'h00, 0, 0, 0, 1, 2'b01, 1, 1, 8'h77, 3'b100);

        repeat (2) @(posedge clk);
        #1;
        check("reset_res", aluRes, 8'h00);
        check("reset_czn", {5'b0, CznToCU}, 8'h00);
`ifdef ALU_OVF_EN
        check("reset_v", {7'b0, vFlag}, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVec; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].aen, vecs[i].ben, vecs[i].az, vecs[i].bz,
                 vecs[i].op, vecs[i].res, vecs[i].ld);
            check($sformatf("vec%0d_res", i), aluRes, vecs[i].exp_res);
            check($sformatf("vec%0d_czn", i), {5'b0, CznToCU}, {5'b0, vecs[i].exp_czn});
        end

        // Same-cycle load of A with a result strobe uses the old A.
        step(8'h01, 8'h01, 1, 1, 0, 0, 2'b00, 0, 0);
        step(8'h09, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0);
        check("samecyc_old_a", aluRes, 8'h02);
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0);
        check("samecyc_new_a", aluRes, 8'h0A);

        // Asynchronous reset mid-cycle with live result and flags.
        step(8'h5A, 8'h00, 1, 1, 0, 0, 2'b00, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0);
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b11, 0, 1);
        check("prereset_res", aluRes, 8'h5A);
        check("prereset_czn", {5'b0, CznToCU}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_res", aluRes, 8'h00);
        check("async_rst_czn", {5'b0, CznToCU}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        // A and B must have been cleared too: 0 + 0 -> Z.
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1);
        check("postrst_res", aluRes, 8'h00);
        check("postrst_czn", {5'b0, CznToCU}, 8'h02);

        // Signed overflow on 7F + 01.
        step(8'h7F, 8'h01, 1, 1, 0, 0, 2'b00, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1);
        check("ovf_add_res", aluRes, 8'h80);
        check("ovf_add_czn", {5'b0, CznToCU}, 8'h01);
`ifdef ALU_OVF_EN
        check("ovf_add_v", {7'b0, vFlag}, 8'h01);
`endif
        step(8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 0, 1);
        check("ovf_and_czn", {5'b0, CznToCU}, 8'h00);
`ifdef ALU_OVF_EN
        check("ovf_and_v", {7'b0, vFlag}, 8'h00);
`endif
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
